// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature direction decoder.
// Holds the phase encoding in forward order, the direction levels, and helpers
// that classify a change of the filtered {A,B} pair.
package quad_pkg;

   // Forward order: PH0 -> PH1 -> PH2 -> PH3 -> PH0
   localparam logic [1:0] PH0 = 2'b00;
   localparam logic [1:0] PH1 = 2'b01;
   localparam logic [1:0] PH2 = 2'b11;
   localparam logic [1:0] PH3 = 2'b10;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   typedef enum logic [1:0] {
      TR_NONE = 2'd0,
      TR_FWD  = 2'd1,
      TR_REV  = 2'd2,
      TR_ERR  = 2'd3
   } trans_e;

   // Forward neighbour of a phase
   function automatic logic [1:0] next_ph(input logic [1:0] ph);
      logic [1:0] nxt;
      case (ph)
         PH0:     nxt = PH1;
         PH1:     nxt = PH2;
         PH2:     nxt = PH3;
         default: nxt = PH0;
      endcase
      return nxt;
   endfunction

   // Classify the move from prev to cur; a diagonal move is the only illegal one
   function automatic trans_e classify(input logic [1:0] prev, input logic [1:0] cur);
      trans_e tr;
      if (cur == prev)               tr = TR_NONE;
      else if (next_ph(prev) == cur) tr = TR_FWD;
      else if (next_ph(cur) == prev) tr = TR_REV;
      else                           tr = TR_ERR;
      return tr;
   endfunction

endpackage

// File: rtl/quad_dir_decoder_if.sv
// Bus bundle between the encoder pins and the decoder outputs.
//   enc_a, enc_b : raw quadrature channels (driven by master)
//   dir, step, err, err_cnt, phase : decoder results (driven by slave)
interface quad_dir_decoder_if #(
   parameter int unsigned ERR_W = 8
);
   logic             enc_a;
   logic             enc_b;
   logic             dir;
   logic             step;
   logic             err;
   logic [ERR_W-1:0] err_cnt;
   logic [1:0]       phase;

   modport master (output enc_a, enc_b, input dir, step, err, err_cnt, phase);
   modport slave  (input enc_a, enc_b, output dir, step, err, err_cnt, phase);
endinterface

// File: rtl/quad_in_filter.sv
// Single-channel conditioner: SYNC_STAGES-flop synchronizer followed by a
// glitch filter that only accepts a level held for FILT_LEN consecutive cycles.
//   clk, rst_n : clock, synchronous active-low reset
//   din        : asynchronous raw input
//   load       : bypass, filtered value follows the synchronizer directly
//   dout       : filtered level (registered)
module quad_in_filter #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_LEN    = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   input  logic load,
   output logic dout
);

   localparam int unsigned CNT_W = $clog2(FILT_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CNT_W-1:0]       cnt;
   logic                   sync_out;

   assign sync_out = sync[SYNC_STAGES-1];

   // Plain shift chain, no logic between stages
   always_ff @(posedge clk) begin
      if (!rst_n) sync <= '0;
      else        sync <= {sync[SYNC_STAGES-2:0], din};
   end

   // Bypass takes the value entering the last sync flop, so once the bypass
   // drops the filtered level already matches the synchronizer output.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout <= 1'b0;
         cnt  <= '0;
      end else if (load) begin
         dout <= sync[SYNC_STAGES-2];
         cnt  <= '0;
      end else if (sync_out == dout) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         dout <= sync_out;
         cnt  <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/quad_dir_decoder.sv
// Quadrature front-end: conditions enc_a/enc_b, then turns each change of the
// filtered phase into a one-cycle step (with direction) or err pulse.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : enc_a/enc_b in; dir, step, err, err_cnt, phase out
module quad_dir_decoder
   import quad_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_LEN    = 4,
   parameter int unsigned ERR_W       = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   quad_dir_decoder_if.slave bus
);

   localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 1);
   localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES - 1);

   logic [ARM_W-1:0] arm_cnt;
   logic             armed;
   logic             dec_en;
   logic             filt_a;
   logic             filt_b;
   logic [1:0]       filt;
   logic [1:0]       ph_prev;
   trans_e           trans_c;

   quad_in_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (bus.enc_a),
      .load (!armed),
      .dout (filt_a)
   );

   quad_in_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (bus.enc_b),
      .load (!armed),
      .dout (filt_b)
   );

   assign filt      = {filt_a, filt_b};
   assign bus.phase = filt;
   assign trans_c   = classify(ph_prev, filt);

   // Arming, transition decode and result registers. dec_en lags armed by one
   // edge so the first comparison uses a ph_prev taken from the settled filters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         arm_cnt     <= '0;
         armed       <= 1'b0;
         dec_en      <= 1'b0;
         ph_prev     <= PH0;
         bus.dir     <= DIR_UP;
         bus.step    <= 1'b0;
         bus.err     <= 1'b0;
         bus.err_cnt <= '0;
      end else begin
         if (!armed) begin
            if (arm_cnt == ARM_LAST) armed   <= 1'b1;
            else                     arm_cnt <= arm_cnt + ARM_W'(1);
         end
         dec_en   <= armed;
         ph_prev  <= filt;
         bus.step <= 1'b0;
         bus.err  <= 1'b0;
         if (dec_en) begin
            case (trans_c)
               TR_FWD: begin
                  bus.step <= 1'b1;
                  bus.dir  <= DIR_UP;
               end
               TR_REV: begin
                  bus.step <= 1'b1;
                  bus.dir  <= DIR_DN;
               end
               TR_ERR: begin
                  bus.err <= 1'b1;
                  if (bus.err_cnt != '1) bus.err_cnt <= bus.err_cnt + ERR_W'(1);
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/quad_dir_decoder.md
Name: quad_dir_decoder

Overview:
Upstream front-end for the up/down counter stage. Turns two asynchronous quadrature inputs (enc_a, enc_b) into a direction level `dir` and a one-cycle `step` enable. Each counter flavour (binary, Gray, one-hot) advances one state per `step` in the direction given by `dir`. The block also detects illegal double-bit transitions and counts them.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops per input channel (minimum 2)
FILT_LEN, 4, consecutive cycles a synchronized input must differ from its filtered value before the filtered value updates (minimum 1)
ERR_W, 8, width of the saturating error counter

Ports:
clk  in  1  system clock, all logic on the rising edge
rst_n  in  1  synchronous active-low reset
enc_a  in  1  quadrature channel A, asynchronous to clk
enc_b  in  1  quadrature channel B, asynchronous to clk
dir  out  1  1 = count up, 0 = count down; holds the last valid direction
step  out  1  one-cycle pulse per valid quadrature transition
err  out  1  one-cycle pulse per illegal transition
err_cnt  out  ERR_W  number of illegal transitions, saturating
phase  out  2  current filtered {A,B}

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low. It is sampled on the rising clk edge and takes effect at that edge.
- Reset values:
  - all synchronizer flops 0
  - filter counters 0
  - filtered A/B 0, so phase = 2'b00
  - dir = 1, step = 0, err = 0, err_cnt = 0
  - armed = 0
- Synchronizer: SYNC_STAGES flops per channel, no logic between stages.
- Glitch filter, per channel, counter width clog2(FILT_LEN+1):
  - On each edge where sync != filt, the counter increments.
  - On the FILT_LEN-th consecutive mismatching edge, filt <= sync and the counter clears.
  - Any edge with sync == filt clears the counter.
  - Pulses shorter than FILT_LEN cycles never reach filt.
- Arming:
  - armed sets on the SYNC_STAGES-th edge after reset release.
  - While armed = 0, filt loads directly from the sync stage each cycle, and step and err stay 0.
  - Result: whatever level the encoder rests at after reset produces no step and no err.
- Phase order, as {A,B}: P0=00, P1=01, P2=11, P3=10.
  - Forward: P0->P1->P2->P3->P0, with wrap-around P3->P0 legal.
- Registered on the edge after filtered {A,B} changes (armed = 1):
  - One bit changed, forward neighbour: step=1, dir=1.
  - One bit changed, reverse neighbour: step=1, dir=0.
  - Both bits changed, including both filters updating on the same edge: err=1, step=0, dir unchanged, err_cnt += 1 saturating at 2^ERR_W-1. Phase takes the new value and decoding continues from it.
  - No change: step=0, err=0.
- Latency from an input edge (stable thereafter) to the step/err pulse: SYNC_STAGES+FILT_LEN+1 clk edges. With defaults this is 7.
- Pulse timing: step and err are exactly one cycle wide and are never high together. Back-to-back valid transitions are limited to at most one per FILT_LEN cycles by the filter.
- phase is the registered filtered value and updates on the same edge as filt.
- Reset mid-operation:
  - Any pending filter count, step or err is discarded.
  - err_cnt clears and dir returns to 1.
  - Re-arming follows the same arming rule as after power-up.

Decomposition:
- Package quad_pkg holds:
  - phase constants PH0..PH3 (2'b00, 2'b01, 2'b11, 2'b10)
  - DIR_UP=1'b1, DIR_DN=1'b0
  - a forward-neighbour function next_ph(ph)
- One sub-module, quad_in_filter: synchronizer plus glitch filter for a single channel, with parameters SYNC_STAGES and FILT_LEN, ports clk, rst_n, din, load (arming bypass), dout. It is instantiated twice.
- The top level holds arming, transition decode, dir/step/err registers and err_cnt.

Test Plan:
1. Default params, hold a=b=0, pulse rst_n low 2 cycles then release, run 20 cycles -> step=0, err=0, dir=1, err_cnt=0, phase=00 throughout.
2. Forward 00->01->11->10->00, each level held 10 cycles -> four step pulses, each exactly 7 edges after its input change; dir=1; err_cnt=0.
3. Reverse 00->10->11->01->00, held 10 cycles each -> four step pulses; dir=0 from the first pulse onward; phase tracks 10,11,01,00.
4. Glitch: from 00, a=1 for 3 cycles then back to 0 -> no step, no err, phase stays 00. Repeat with a 4-cycle pulse -> step with dir=1, then step with dir=0.
5. Diagonal 00->11 (a and b change on the same edge) -> one err pulse, no step, dir unchanged, err_cnt=1. With ERR_W=2, five diagonals -> err_cnt saturates at 3.
6. After forward steps, inputs at 11, assert rst_n low 1 cycle mid-filter-count -> outputs return to reset values, no step/err on re-arm, phase=11 after arming. Then 11->10 -> single step with dir=1.
